shift_ser_ctrl: RTL and testbench

SHIFT_SER_CTRL -- requirements
Module: shift_ser_ctrl

---
 rtl/shift_ser_ctrl.sv | 71 +++++++
 tb/tb_shift_ser_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl: serialises parallel words MSB-first by steering an external left-shift register
module shift_ser_ctrl #(
    parameter int   DW   = 4,
    parameter logic FILL = 1'b0
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          sr_load,
    output logic          sr_en,
    output logic [DW-1:0] sr_data,
    output logic          sr_data_l,
    input  logic [DW-1:0] sr_q,
    output logic          sout,
    output logic          sout_valid,
    input  logic          sout_ready,
    output logic          sout_last,
    input  logic          flush,
    output logic          busy,
    output logic [15:0]   word_cnt
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   word_cnt_q;
    logic          last;
    logic          done;

    assign last       = (state_q == SHIFT) && (cnt_q == LAST);
    assign done       = last && sout_ready && !flush;
    // flush also blocks acceptance so a word is never dropped after a handshake
    assign in_ready   = !flush && ((state_q == IDLE) || (last && sout_ready));
    assign sr_load    = in_valid && in_ready;
    assign sr_en      = (state_q == SHIFT) && sout_ready && !last && !flush;
    assign sr_data    = in_data;
    assign sr_data_l  = FILL;
    assign sout       = sr_q[DW-1];
    assign sout_valid = (state_q == SHIFT);
    assign sout_last  = last;
    assign busy       = (state_q == SHIFT);
    assign word_cnt   = word_cnt_q;

    // Control FSM: flush beats load, load beats shift, last-bit handshake ends the word
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (sr_load) begin
                state_q <= SHIFT;
                cnt_q   <= '0;
            end else if (sr_en) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (done) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end
            if (done) word_cnt_q <= word_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_shift_ser_ctrl.sv
// tb_shift_ser_ctrl: directed tests of the serialiser controller driving a modelled shift register
module tb_shift_ser_ctrl;
    logic        clk = 1'b0;
    logic        async_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = 4'h0;
    logic        sr_load;
    logic        sr_en;
    logic [3:0]  sr_data;
    logic        sr_data_l;
    logic [3:0]  sr_q = 4'h0;
    logic        sout;
    logic        sout_valid;
    logic        sout_ready = 1'b1;
    logic        sout_last;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] word_cnt;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_wc = 16'd0;

    shift_ser_ctrl #(.DW(4), .FILL(1'b0)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sr_load(sr_load), .sr_en(sr_en), .sr_data(sr_data),
        .sr_data_l(sr_data_l), .sr_q(sr_q), .sout(sout), .sout_valid(sout_valid),
        .sout_ready(sout_ready), .sout_last(sout_last), .flush(flush), .busy(busy),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // External shift register the controller steers
    always @(posedge clk) begin
        if (sr_load) sr_q <= sr_data;
        else if (sr_en) sr_q <= {sr_q[2:0], sr_data_l};
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        #2;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (sr_load !== 1'b1) begin failures++; $display("FAIL rst_sr_load got=%b exp=1", sr_load); end
        checks++; if (sout_valid !== 1'b0 || busy !== 1'b0 || sout_last !== 1'b0 || sr_en !== 1'b0) begin
            failures++; $display("FAIL rst_outs got=%b%b%b%b exp=0000", sout_valid, busy, sout_last, sr_en); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL rst_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (sr_data_l !== 1'b0) begin failures++; $display("FAIL fill got=%b exp=0", sr_data_l); end
        in_valid = 1'b0;
        cyc();
        async_rst_n = 1'b1;
        cyc();
    endtask

    task automatic send_word(input logic [3:0] w, input string tag);
        in_data = w;
        in_valid = 1'b1;
        #1;
        checks++; if (sr_load !== 1'b1 || sr_data !== w) begin
            failures++; $display("FAIL %s_load got=%b/%h exp=1/%h", tag, sr_load, sr_data, w); end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic expect_bits(input logic [3:0] w, input string tag);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sout !== w[3-i] || sout_valid !== 1'b1 || sout_last !== (i == 3)) begin
                failures++; $display("FAIL %s_bit%0d got=%b/%b/%b exp=%b/1/%b", tag, i, sout, sout_valid, sout_last, w[3-i], i == 3); end
            cyc();
        end
        exp_wc = exp_wc + 16'd1;
        checks++; if (word_cnt !== exp_wc) begin failures++; $display("FAIL %s_wc got=%0d exp=%0d", tag, word_cnt, exp_wc); end
    endtask

    task automatic test_basic;
        send_word(4'b1011, "basic");
        expect_bits(4'b1011, "basic");
        checks++; if (busy !== 1'b0 || sout_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_idle got=%b%b%b exp=001", busy, sout_valid, in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        in_data = 4'hA;
        in_valid = 1'b1;
        cyc();
        in_data = 4'h5;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (sout !== exp_bits[7-i] || busy !== 1'b1) begin
                failures++; $display("FAIL b2b_bit%0d got=%b/%b exp=%b/1", i, sout, busy, exp_bits[7-i]); end
            checks++; if (in_ready !== (i == 3 || i == 7)) begin
                failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, in_ready, i == 3 || i == 7); end
            cyc();
            if (i == 3) in_valid = 1'b0;
        end
        exp_wc = exp_wc + 16'd2;
        checks++; if (word_cnt !== exp_wc || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_end got=%0d/%b exp=%0d/0", word_cnt, busy, exp_wc); end
    endtask

    task automatic test_stall;
        send_word(4'b1100, "stall");
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (sout !== 1'b1) begin failures++; $display("FAIL stall_bit%0d got=%b exp=1", i, sout); end
            cyc();
        end
        sout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sout !== 1'b0 || sr_en !== 1'b0 || sout_last !== 1'b0 || sr_q !== 4'b0000) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%b/%b/%b exp=0/0/0/0000", i, sout, sr_en, sout_last, sr_q); end
            cyc();
        end
        sout_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (sout !== 1'b0 || sout_last !== (i == 1)) begin
                failures++; $display("FAIL stall_tail%0d got=%b/%b exp=0/%b", i, sout, sout_last, i == 1); end
            cyc();
        end
        exp_wc = exp_wc + 16'd1;
        checks++; if (word_cnt !== exp_wc || busy !== 1'b0) begin
            failures++; $display("FAIL stall_end got=%0d/%b exp=%0d/0", word_cnt, busy, exp_wc); end
    endtask

    task automatic test_reset_mid;
        send_word(4'hF, "rmid");
        cyc();
        async_rst_n = 1'b0;
        #1;
        exp_wc = 16'd0;
        checks++; if (sout_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd0) begin
            failures++; $display("FAIL rmid_async got=%b/%b/%0d exp=0/0/0", sout_valid, busy, word_cnt); end
        #1;
        async_rst_n = 1'b1;
        cyc();
        send_word(4'h9, "rmid9");
        expect_bits(4'h9, "rmid9");
    endtask

    task automatic test_flush;
        send_word(4'h6, "flush");
        cyc();
        cyc();
        flush = 1'b1;
        #1;
        checks++; if (sr_en !== 1'b0 || sr_load !== 1'b0) begin
            failures++; $display("FAIL flush_strobes got=%b/%b exp=0/0", sr_en, sr_load); end
        cyc();
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || sout_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== exp_wc) begin
            failures++; $display("FAIL flush_idle got=%b/%b/%b/%0d exp=0/0/1/%0d", busy, sout_valid, in_ready, word_cnt, exp_wc); end
        send_word(4'h3, "flush3");
        expect_bits(4'h3, "flush3");
    endtask

    task automatic test_wrap;
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        #1;
        checks++; if (word_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=ffff", word_cnt); end
        exp_wc = 16'hFFFF;
        send_word(4'h8, "wrap");
        expect_bits(4'h8, "wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
